// File: rtl/lin_enc_pkg.sv
// rtl/lin_enc_pkg.sv - default code parameters and occupancy encodings for the linear block encoder
package lin_enc_pkg;

  localparam int LIN_K     = 7;
  localparam int LIN_R     = 5;
  localparam int LIN_CNT_W = 16;

  // Row r of the parity matrix lives at [r*K +: K]; the last literal is row 0.
  localparam logic [LIN_R*LIN_K-1:0] LIN_P_MATRIX =
    {7'b1101010, 7'b1101011, 7'b1101011, 7'b0110101, 7'b1100011};

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/lin_parity_gen.sv
// rtl/lin_parity_gen.sv - combinational parity bits of a message word against a fixed matrix
module lin_parity_gen
  import lin_enc_pkg::*;
#(
  parameter int                 K        = LIN_K,
  parameter int                 R        = LIN_R,
  parameter logic [R*K-1:0]     P_MATRIX = LIN_P_MATRIX
) (
  input  logic [K-1:0] data,
  output logic [R-1:0] parity
);

  for (genvar r = 0; r < R; r++) begin : g_row
    assign parity[r] = ^(data & P_MATRIX[r*K +: K]);
  end

endmodule

// File: rtl/lin_encoder_stream.sv
// rtl/lin_encoder_stream.sv - streaming systematic linear encoder with a 2-entry output FIFO
// and a delivered-codeword counter.
module lin_encoder_stream
  import lin_enc_pkg::*;
#(
  parameter int             K        = LIN_K,
  parameter int             R        = LIN_R,
  parameter logic [R*K-1:0] P_MATRIX = LIN_P_MATRIX,
  parameter int             CNT_W    = LIN_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [K-1:0]     in_data,
  input  logic [K+R-1:0]   in_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K+R-1:0]   out_code,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt
);

  logic [R-1:0]   parity;
  logic [K+R-1:0] code;
  logic [K+R-1:0] mem [2];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     occ;
  logic [1:0]     occ_next;
  logic           in_fire;
  logic           out_fire;

  lin_parity_gen #(
    .K        (K),
    .R        (R),
    .P_MATRIX (P_MATRIX)
  ) u_parity (
    .data   (in_data),
    .parity (parity)
  );

  assign code      = {parity, in_data} ^ in_err;
  assign out_valid = (occ != OCC_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  // Storage is unreset, so the output is gated to read zero whenever nothing is buffered.
  assign out_code  = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    occ_next = occ;
    case ({in_fire, out_fire})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= OCC_EMPTY;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      in_ready <= 1'b1;
      cnt      <= '0;
    end else begin
      occ      <= occ_next;
      in_ready <= (occ_next != OCC_FULL);
      if (in_fire) begin
        wr_ptr <= ~wr_ptr;
      end
      if (out_fire) begin
        rd_ptr <= ~rd_ptr;
      end
      if (cnt_clr) begin
        cnt <= '0;
      end else if (out_fire) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_ptr] <= code;
    end
  end

endmodule

// File: tb/tb_lin_encoder_stream.sv
// tb/tb_lin_encoder_stream.sv - self-checking bench for lin_encoder_stream
module tb_lin_encoder_stream;

  localparam int K     = 7;
  localparam int R     = 5;
  localparam int CNT_W = 4;
  localparam logic [R*K-1:0] PM =
    {7'b1101010, 7'b1101011, 7'b1101011, 7'b0110101, 7'b1100011};

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [K-1:0]     in_data;
  logic [K+R-1:0]   in_err;
  logic             out_valid;
  logic             out_ready;
  logic [K+R-1:0]   out_code;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt;

  int n_tests = 0;
  int n_fail  = 0;

  lin_encoder_stream #(
    .K        (K),
    .R        (R),
    .P_MATRIX (PM),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .cnt_clr   (cnt_clr),
    .cnt       (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [K+R-1:0] ref_code(input logic [K-1:0] d, input logic [K+R-1:0] e);
    logic [R-1:0] p;
    for (int r = 0; r < R; r++) begin
      p[r] = 1'b0;
      for (int j = 0; j < K; j++) p[r] = p[r] ^ (d[j] & PM[r*K + j]);
    end
    return {p, d} ^ e;
  endfunction

  logic [K+R-1:0] sb [$];
  int sent;
  int got_n;
  int cyc;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_err = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_cnt", cnt, 0);
    check("rst_out_code", out_code, 0);
    reset = 1'b0;

    // single word, 1-cycle latency
    in_valid = 1'b1; in_data = 7'h01;
    step();
    in_valid = 1'b0;
    check("lat_out_valid", out_valid, 1'b1);
    check("code_01", out_code, 12'h781);
    step();
    check("cnt_after_1", cnt, 1);
    check("drained_valid", out_valid, 1'b0);

    // error injection
    in_valid = 1'b1; in_data = 7'h7F; in_err = 12'h800;
    step();
    in_valid = 1'b0; in_err = '0;
    check("code_7f_err", out_code, 12'hE7F);
    step();
    check("cnt_after_2", cnt, 2);

    // backpressure with three words
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h01;
    step();
    check("bp_ready_one", in_ready, 1'b1);
    in_data = 7'h02;
    step();
    check("bp_ready_full", in_ready, 1'b0);
    check("bp_head", out_code, 12'h781);
    in_data = 7'h7F;
    step();
    check("bp_ready_held", in_ready, 1'b0);
    check("bp_head_held", out_code, 12'h781);
    out_ready = 1'b1;
    step();
    check("bp_second", out_code, 12'hE82);
    check("bp_ready_back", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    check("bp_third", out_code, 12'h67F);
    step();
    check("bp_empty", out_valid, 1'b0);
    check("cnt_after_5", cnt, 5);

    // counter wrap at CNT_W=4 and clear
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_clr_idle", cnt, 0);
    in_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_data = 7'(i + 3);
      step();
      check("stream_valid", out_valid, 1'b1);
      check("stream_code", out_code, ref_code(7'(i + 3), '0));
    end
    in_valid = 1'b0;
    step();
    check("cnt_wrap_17", cnt, 1);
    in_valid = 1'b1; in_data = 7'h01;
    step();
    in_valid = 1'b0; cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("cnt_clr_wins", cnt, 0);
    check("clr_delivered", out_valid, 1'b0);

    // asynchronous reset while full
    in_valid = 1'b1; in_data = 7'h05;
    step();
    in_valid = 1'b0;
    step();
    check("pre_rst_cnt", cnt, 1);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 7'h11;
    step();
    in_data = 7'h22;
    step();
    in_valid = 1'b0;
    check("full_ready", in_ready, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_cnt", cnt, 0);
    check("arst_out_code", out_code, 0);
    step();
    reset = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_data = 7'h01;
    step();
    in_valid = 1'b0;
    check("post_rst_code", out_code, 12'h781);
    step();
    check("post_rst_cnt", cnt, 1);

    // random traffic against the reference model
    sent = 0; got_n = 0; cyc = 0;
    while (got_n < 10000 && cyc < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_data   = K'($urandom);
      in_err    = ($urandom_range(7) == 0) ? (K+R)'($urandom) : '0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rnd_spurious", 1, 0);
        else check("rnd_code", out_code, sb.pop_front());
        got_n++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_code(in_data, in_err));
        sent++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    check("rnd_all_delivered", got_n, 10000);
    check("rnd_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lin_encoder_stream.md
LIN_ENCODER_STREAM -- requirements
Module: lin_encoder_stream

Interface
REQ-001 Parameter K, default 7: message width in bits (2..64).
REQ-002 Parameter R, default 5: parity width in bits (1..32).
REQ-003 Parameter P_MATRIX, width R*K, default {7'b1101010,7'b1101011,7'b1101011,7'b0110101,7'b1100011}: row r is P_MATRIX[r*K +: K], and message bit j feeds parity bit r when row bit j is 1.
REQ-004 Parameter CNT_W, default 16: width of the codeword counter.
REQ-005 clk  input  1  the single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 in_valid  input  1  the message word is valid.
REQ-008 in_ready  output  1  the block can accept a word this cycle.
REQ-009 in_data  input  K  message word.
REQ-010 in_err  input  K+R  error-injection mask, sampled with in_data.
REQ-011 out_valid  output  1  the codeword is valid.
REQ-012 out_ready  input  1  the downstream side accepts the codeword.
REQ-013 out_code  output  K+R  codeword: [K-1:0] = message, [K+R-1:K] = parity, then XOR with the captured in_err.
REQ-014 cnt_clr  input  1  synchronous clear of the codeword counter.
REQ-015 cnt  output  CNT_W  number of codewords delivered, modulo 2^CNT_W.

Function
REQ-016 Parity bit r SHALL be the XOR reduction of (in_data AND row r), computed combinationally at acceptance.
REQ-017 A transfer SHALL occur on the input when in_valid && in_ready, and on the output when out_valid && out_ready.
REQ-018 An accepted word SHALL be encoded and stored in a 2-entry FIFO; out_code SHALL be driven from the head entry.
REQ-019 Latency SHALL be 1 cycle: a word accepted in cycle n, with the FIFO empty, SHALL appear with out_valid=1 in cycle n+1.
REQ-020 in_ready SHALL be a registered signal equal to (occupancy < 2); it SHALL NOT combinationally depend on out_ready.
REQ-021 Simultaneous input and output transfer SHALL leave occupancy unchanged, including when occupancy is 2, where in_ready stays 1 only if it was already 1.
REQ-022 Sustained in_valid=1 and out_ready=1 SHALL give one codeword per cycle.
REQ-023 While out_valid=1 and out_ready=0, out_code SHALL hold stable.
REQ-024 Order SHALL be preserved; no word SHALL be dropped or duplicated.
REQ-025 FIFO pointers SHALL wrap modulo 2; occupancy SHALL be in 0..2.
REQ-026 cnt SHALL increment by 1 per output transfer and wrap from 2^CNT_W-1 to 0.
REQ-027 When cnt_clr=1 in the same cycle as an output transfer, cnt SHALL become 0 (clear wins).
REQ-028 Occupancy states SHALL be: EMPTY (out_valid=0, in_ready=1), ONE (out_valid=1, in_ready=1), FULL (out_valid=1, in_ready=0).

Reset
REQ-029 Asserting reset SHALL immediately force out_valid=0, in_ready=1, cnt=0, occupancy=0, and pointers=0.
REQ-030 out_code SHALL reset to all zeros; FIFO storage needs no reset.
REQ-031 Reset asserted mid-stream SHALL discard all buffered words; the first word after deassertion SHALL be treated as the first codeword.

Structure
REQ-032 The package lin_enc_pkg SHALL hold the default K, R, P_MATRIX and CNT_W constants.
REQ-033 Parity computation SHALL be a combinational sub-module lin_parity_gen, parameterised by K, R and P_MATRIX.
REQ-034 The handshake FIFO and the counter SHALL be inline in lin_encoder_stream.

Verification
REQ-035 Defaults; in_data=7'h01, in_err=0, out_ready=1 -> next cycle out_valid=1, out_code=12'h781, cnt=1.
REQ-036 Defaults; in_data=7'h7F, in_err=12'h800 -> out_code=12'hE7F (base 12'h67F with bit 11 flipped).
REQ-037 out_ready=0; present three words -> in_ready=0 after two are accepted; raising out_ready delivers them in order with held values.
REQ-038 Random in_valid/out_ready over 10k words -> scoreboard match against the P_MATRIX reference model, with no loss or reorder.
REQ-039 CNT_W=4; deliver 17 words -> cnt=1; assert cnt_clr together with a transfer -> cnt=0.
REQ-040 Assert reset while FULL -> asynchronously out_valid=0, in_ready=1, cnt=0; post-reset word 7'h01 -> 12'h781.
